// File: rtl/fir_tap_sequencer.sv
// Coefficient bank and sequencer for a shift-loaded FIR: it shifts the bank into the
// filter, flushes the filter pipeline with zeros, then forwards upstream samples.
module fir_tap_sequencer #(
    parameter int NTAPS = 4,
    parameter int TW    = 12,
    parameter int IW    = 12,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_coef_wr,
    input  logic [AW-1:0] i_coef_addr,
    input  logic [TW-1:0] i_coef,
    input  logic          i_load,
    input  logic          i_ce,
    input  logic [IW-1:0] i_sample,
    output logic          o_tap_wr,
    output logic [TW-1:0] o_tap,
    output logic          o_ce,
    output logic [IW-1:0] o_sample,
    output logic          o_busy,
    output logic          o_loaded,
    output logic          o_done
);

    localparam int CW = $clog2(NTAPS + 2);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    logic [TW-1:0] bank      [NTAPS];
    logic [TW-1:0] bank_next [NTAPS];

    logic [31:0]   addr_ext;
    logic          coef_we;
    logic          pass_sample;
    logic          tap_wr_next;
    logic [TW-1:0] tap_next;
    logic          ce_next;
    logic [IW-1:0] sample_next;
    logic          busy_next;
    logic          done_next;
    logic          loaded_next;

    assign addr_ext = 32'(i_coef_addr);
    assign coef_we  = i_coef_wr && (state == IDLE || state == RUN) && (addr_ext < 32'(NTAPS));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt walks the tap index down during LOAD, then the flush length during FLUSH
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE, RUN: begin
                if (i_load) begin
                    state_next = LOAD;
                    cnt_next   = CW'(NTAPS - 1);
                end
            end
            LOAD: begin
                if (cnt == '0) begin
                    state_next = FLUSH;
                    cnt_next   = CW'(NTAPS + 1);
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            FLUSH: begin
                if (cnt == '0) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // The tap read uses the post-write bank so a write coinciding with i_load is shifted out
    always_comb begin
        bank_next = bank;
        for (int k = 0; k < NTAPS; k++) begin
            if (coef_we && addr_ext == 32'(k)) begin
                bank_next[k] = i_coef;
            end
        end
    end

    always_comb begin
        tap_wr_next = (state_next == LOAD);
        tap_next    = '0;
        if (tap_wr_next) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (cnt_next == CW'(k)) begin
                    tap_next = bank_next[k];
                end
            end
        end
        // Samples seen outside a settled RUN cycle are dropped rather than forwarded
        pass_sample = (state == RUN) && (state_next == RUN) && i_ce;
        ce_next     = (state_next == FLUSH) || pass_sample;
        sample_next = pass_sample ? i_sample : '0;
        busy_next   = (state_next == LOAD) || (state_next == FLUSH);
        done_next   = (state == FLUSH) && (state_next == RUN);
        if (state_next == LOAD) begin
            loaded_next = 1'b0;
        end else if (done_next) begin
            loaded_next = 1'b1;
        end else begin
            loaded_next = o_loaded;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                bank[k] <= '0;
            end
            o_tap_wr <= 1'b0;
            o_tap    <= '0;
            o_ce     <= 1'b0;
            o_sample <= '0;
            o_busy   <= 1'b0;
            o_loaded <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            bank     <= bank_next;
            o_tap_wr <= tap_wr_next;
            o_tap    <= tap_next;
            o_ce     <= ce_next;
            o_sample <= sample_next;
            o_busy   <= busy_next;
            o_loaded <= loaded_next;
            o_done   <= done_next;
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer driving a behavioural shift-loaded FIR model.
module tb_fir_tap_sequencer;

    localparam int NTAPS = 4;
    localparam int TW    = 12;
    localparam int IW    = 12;
    localparam int AW    = 3;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_coef_wr;
    logic [AW-1:0] i_coef_addr;
    logic [TW-1:0] i_coef;
    logic          i_load;
    logic          i_ce;
    logic [IW-1:0] i_sample;
    logic          o_tap_wr;
    logic [TW-1:0] o_tap;
    logic          o_ce;
    logic [IW-1:0] o_sample;
    logic          o_busy;
    logic          o_loaded;
    logic          o_done;

    int checks   = 0;
    int failures = 0;

    int exp_tap_q[$];
    int exp_sample_q[$];
    int exp_fir_q[$];
    int bank_m[NTAPS];

    int fir_tap[NTAPS];
    int fir_x[NTAPS];
    int fir_sum;
    int fir_y;
    logic fir_run_valid;

    fir_tap_sequencer #(
        .NTAPS(NTAPS),
        .TW   (TW),
        .IW   (IW),
        .AW   (AW)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_coef_wr  (i_coef_wr),
        .i_coef_addr(i_coef_addr),
        .i_coef     (i_coef),
        .i_load     (i_load),
        .i_ce       (i_ce),
        .i_sample   (i_sample),
        .o_tap_wr   (o_tap_wr),
        .o_tap      (o_tap),
        .o_ce       (o_ce),
        .o_sample   (o_sample),
        .o_busy     (o_busy),
        .o_loaded   (o_loaded),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Attached FIR: taps shift in at tap0, so the last tap shifted lands in tap0
    always_comb begin
        fir_sum = int'($signed(o_sample)) * fir_tap[0];
        for (int k = 1; k < NTAPS; k++) begin
            fir_sum = fir_sum + fir_x[k-1] * fir_tap[k];
        end
    end

    always @(posedge i_clk) begin
        if (i_reset) begin
            fir_run_valid <= 1'b0;
            fir_y         <= 0;
        end else begin
            if (o_tap_wr) begin
                fir_tap[0] <= int'($signed(o_tap));
                for (int k = 1; k < NTAPS; k++) fir_tap[k] <= fir_tap[k-1];
            end
            fir_run_valid <= o_ce && !o_busy;
            if (o_ce) begin
                fir_y    <= fir_sum;
                fir_x[0] <= int'($signed(o_sample));
                for (int k = 1; k < NTAPS; k++) fir_x[k] <= fir_x[k-1];
            end
        end
    end

    always @(negedge i_clk) begin
        if (o_tap_wr) begin
            if (exp_tap_q.size() == 0) checkOutput("tap_unexpected", 32'(o_tap), 32'hFFFF_FFFF);
            else checkOutput("tap", 32'(o_tap), exp_tap_q.pop_front());
        end else begin
            checkOutput("tap_zero", 32'(o_tap), 0);
        end
        if (!o_ce) checkOutput("sample_zero", 32'(o_sample), 0);
        else if (o_busy) checkOutput("flush_sample", 32'(o_sample), 0);
        else if (exp_sample_q.size() == 0) checkOutput("sample_unexpected", 32'(o_sample), 32'hFFFF_FFFF);
        else checkOutput("run_sample", 32'(o_sample), exp_sample_q.pop_front());
        if (fir_run_valid === 1'b1) begin
            if (exp_fir_q.size() == 0) checkOutput("fir_unexpected", fir_y, 32'hFFFF_FFFF);
            else checkOutput("fir_out", fir_y, exp_fir_q.pop_front());
        end
    end

    task automatic applyStimulus(input logic load, input logic wr, input int addr, input int coef,
                                 input logic ce, input int sample);
        i_load      = load;
        i_coef_wr   = wr;
        i_coef_addr = AW'(addr);
        i_coef      = TW'(coef);
        i_ce        = ce;
        i_sample    = IW'(sample);
        @(posedge i_clk);
        #1;
    endtask

    task automatic writeCoef(input int addr, input int coef);
        if (addr < NTAPS) bank_m[addr] = coef;
        applyStimulus(1'b0, 1'b1, addr, coef, 1'b0, 0);
    endtask

    task automatic startLoad(input logic wr, input int addr, input int coef);
        if (wr && addr < NTAPS) bank_m[addr] = coef;
        for (int k = NTAPS - 1; k >= 0; k--) exp_tap_q.push_back(bank_m[k]);
        applyStimulus(1'b1, wr, addr, coef, 1'b0, 0);
        checkOutput("load_entry_busy", 32'(o_busy), 1);
        checkOutput("load_entry_loaded", 32'(o_loaded), 0);
    endtask

    // Cycle indices count busy cycles from 1; pokes drive inputs during that cycle
    task automatic finishLoad(input int poke_a, input int poke_b, input int wr_cycle,
                              input int wr_addr, input int wr_val);
        int busy_cycles;
        int tap_cycles;
        int flush_cycles;
        int guard;
        bit done_seen;
        busy_cycles  = 1;
        tap_cycles   = 1;
        flush_cycles = 0;
        guard        = 0;
        done_seen    = 1'b0;
        while (!done_seen && guard < 40) begin
            applyStimulus((busy_cycles == poke_a) || (busy_cycles == poke_b),
                          busy_cycles == wr_cycle, wr_addr, wr_val,
                          busy_cycles <= NTAPS + 1, 5);
            guard++;
            if (o_busy) begin
                busy_cycles++;
                checkOutput("loaded_while_busy", 32'(o_loaded), 0);
                if (o_tap_wr) checkOutput("ce_in_load", 32'(o_ce), 0);
            end
            if (o_tap_wr) tap_cycles++;
            if (o_ce && o_busy) flush_cycles++;
            if (o_done) done_seen = 1'b1;
        end
        checkOutput("done_seen", 32'(done_seen), 1);
        checkOutput("busy_cycles", busy_cycles, 2 * NTAPS + 2);
        checkOutput("tap_cycles", tap_cycles, NTAPS);
        checkOutput("flush_cycles", flush_cycles, NTAPS + 2);
        checkOutput("done_busy", 32'(o_busy), 0);
        checkOutput("done_loaded", 32'(o_loaded), 1);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
        checkOutput("done_pulse_end", 32'(o_done), 0);
        checkOutput("loaded_hold", 32'(o_loaded), 1);
        checkOutput("tap_queue_empty", exp_tap_q.size(), 0);
        for (int k = 0; k < NTAPS; k++) checkOutput($sformatf("fir_tap%0d", k), fir_tap[k], bank_m[k]);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_load = 1'b0; i_coef_wr = 1'b0; i_coef_addr = '0; i_coef = '0; i_ce = 1'b0; i_sample = '0;
        for (int k = 0; k < NTAPS; k++) bank_m[k] = 0;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("rst_tap_wr", 32'(o_tap_wr), 0);
        checkOutput("rst_ce", 32'(o_ce), 0);
        checkOutput("rst_busy", 32'(o_busy), 0);
        checkOutput("rst_loaded", 32'(o_loaded), 0);
        checkOutput("rst_done", 32'(o_done), 0);
        i_reset = 1'b0;

        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 5);
        checkOutput("idle_ce_dropped", 32'(o_ce), 0);

        $display("[TB] basic load of bank 1..4");
        for (int k = 0; k < NTAPS; k++) writeCoef(k, k + 1);
        startLoad(1'b0, 0, 0);
        finishLoad(0, 0, 0, 0, 0);

        $display("[TB] impulse through the loaded FIR");
        for (int n = 0; n < 8; n++) begin
            exp_sample_q.push_back(n == 0 ? 1 : 0);
            exp_fir_q.push_back(n < NTAPS ? bank_m[n] : 0);
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, n == 0 ? 1 : 0);
        end
        repeat (3) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
        checkOutput("sample_queue_empty", exp_sample_q.size(), 0);
        checkOutput("fir_queue_empty", exp_fir_q.size(), 0);

        $display("[TB] ignored loads and writes");
        writeCoef(5, 11);
        startLoad(1'b0, 0, 0);
        finishLoad(2, NTAPS + 3, NTAPS + 3, 2, 7);

        $display("[TB] load with coincident write");
        startLoad(1'b1, 0, 9);
        finishLoad(0, 0, 0, 0, 0);

        $display("[TB] reset during load");
        startLoad(1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
        i_reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 0, 9, 1'b1, 3);
        i_reset = 1'b0;
        exp_tap_q.delete();
        for (int k = 0; k < NTAPS; k++) bank_m[k] = 0;
        checkOutput("abort_tap_wr", 32'(o_tap_wr), 0);
        checkOutput("abort_busy", 32'(o_busy), 0);
        checkOutput("abort_ce", 32'(o_ce), 0);
        checkOutput("abort_loaded", 32'(o_loaded), 0);
        checkOutput("abort_done", 32'(o_done), 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
        checkOutput("abort_stays_idle", 32'(o_busy), 0);
        startLoad(1'b0, 0, 0);
        finishLoad(0, 0, 0, 0, 0);

        repeat (2) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
        checkOutput("final_sample_queue", exp_sample_q.size(), 0);
        checkOutput("final_fir_queue", exp_fir_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
